// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - OV7670 capture sequencer: button debounce, one-frame arm, BRAM write path
// Optional capture watchdog is compiled in when CAPTURE_TIMEOUT_EN is defined.
module capture_sequencer #(
    parameter int H_PIXELS        = 320,
    parameter int V_PIXELS        = 240,
    parameter int ADDR_W          = 17,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int TIMEOUT_CYCLES  = 2000000
) (
    input  logic              p_clock_in,
    input  logic              rst_n_in,
    input  logic              start_button_in,
    input  logic              pixel_valid_in,
    input  logic [15:0]       pixel_data_in,
    input  logic              frame_done_in,
    output logic              cam_arm_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic              busy_out,
    output logic              frame_ready_out,
    output logic [ADDR_W-1:0] pixel_count_out,
    output logic              overflow_out,
    output logic              timeout_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_PIXELS * V_PIXELS);

    // pixel_count_out has to hold the full-frame count, not just the last address
    if ((TIMEOUT_CYCLES < 1) || (DEBOUNCE_CYCLES < 1) ||
        ((64'd1 << ADDR_W) <= 64'(H_PIXELS * V_PIXELS))) begin : g_bad_config
        $error("capture_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_q, db_d, db_dly_q;
    logic              start;
    logic              wd_hit;
    logic              arm_entry, accept;
    logic              cam_arm_q, cam_arm_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_ready_q, frame_ready_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;

    // Debounced level needs DEBOUNCE_CYCLES consecutive high samples, drops on the first low one
    always_comb begin
        db_cnt_d = '0;
        if (sync2_q) begin
            db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
        end
        db_d = sync2_q && (db_cnt_q == DB_MAX);
    end

    assign start = db_q & ~db_dly_q;

    always_ff @(posedge p_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync1_q  <= start_button_in;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q;

    always_comb begin
        wd_cnt_d = '0;
        wd_hit   = 1'b0;
        if ((state_q == S_ARM || state_q == S_CAPTURE) && !pixel_valid_in) begin
            wd_hit   = (wd_cnt_q == WD_LAST);
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge p_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (arm_entry) begin
                timeout_q <= 1'b0;
            end else if (wd_hit && state_d == S_ERROR) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_out = timeout_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_out = 1'b0;
`endif

    always_ff @(posedge p_clock_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            cam_arm_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cam_arm_q     <= cam_arm_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_ready_q <= frame_ready_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = wd_hit ? S_ERROR : S_CAPTURE;
            end
            S_CAPTURE: begin
                // A coincident pixel is still handled by the datapath below
                if (frame_done_in)  state_d = S_DONE;
                else if (wd_hit)    state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arm_entry     = (state_d == S_ARM) && (state_q != S_ARM);
        accept        = (state_q == S_CAPTURE) && pixel_valid_in && (count_q < FRAME_PIX);
        cam_arm_d     = arm_entry;
        wr_en_d       = accept;
        busy_d        = (state_d == S_ARM) || (state_d == S_CAPTURE);
        frame_ready_d = (state_d == S_DONE);
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        if (arm_entry) begin
            wr_addr_d  = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            wr_addr_d = count_q;
            wr_data_d = pixel_data_in;
            count_d   = count_q + 1'b1;
        end else if (state_q == S_CAPTURE && pixel_valid_in) begin
            overflow_d = 1'b1;
        end
    end

    assign cam_arm_out     = cam_arm_q;
    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign busy_out        = busy_q;
    assign frame_ready_out = frame_ready_q;
    assign pixel_count_out = count_q;
    assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
// Covers debounce, full frame, overflow, coincident end-of-frame, watchdog (CAPTURE_TIMEOUT_EN) and async reset.
module tb_capture_sequencer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 4;
    localparam int DEB   = 4;
    localparam int TMO   = 50;
    localparam int FRAME = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          button = 1'b0;
    logic          pvalid = 1'b0;
    logic [15:0]   pdata = '0;
    logic          fdone = 1'b0;
    logic          cam_arm_out, wr_en_out, busy_out, frame_ready_out, overflow_out, timeout_out;
    logic [AW-1:0] wr_addr_out, pixel_count_out;
    logic [15:0]   wr_data_out;

    always #5 clk = ~clk;

    capture_sequencer #(
        .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW),
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .p_clock_in(clk), .rst_n_in(rst_n), .start_button_in(button),
        .pixel_valid_in(pvalid), .pixel_data_in(pdata), .frame_done_in(fdone),
        .cam_arm_out(cam_arm_out), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .busy_out(busy_out), .frame_ready_out(frame_ready_out),
        .pixel_count_out(pixel_count_out), .overflow_out(overflow_out), .timeout_out(timeout_out)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    int arm_cnt = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    // Reference model: expected write stream, frame memory and status flags
    wr_t         exp_q[$];
    logic [15:0] m_mem [0:FRAME-1];
    logic [15:0] bram  [0:FRAME-1];
    int          m_count = 0;
    bit          m_ovf = 1'b0;
    bit          m_capturing = 1'b0;
    bit          m_ready = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_pixel(input logic [15:0] d);
        wr_t w;
        if (!m_capturing) return;
        if (m_count < FRAME) begin
            w.addr = m_count[AW-1:0];
            w.data = d;
            exp_q.push_back(w);
            m_mem[m_count] = d;
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic drive_pixel(input logic [15:0] d, input bit with_done);
        pvalid = 1'b1;
        pdata  = d;
        fdone  = with_done;
        model_pixel(d);
        if (with_done && m_capturing) begin
            m_capturing = 1'b0;
            m_ready     = 1'b1;
        end
        step();
        pvalid = 1'b0;
        fdone  = 1'b0;
    endtask

    task automatic end_frame();
        fdone = 1'b1;
        if (m_capturing) begin
            m_capturing = 1'b0;
            m_ready     = 1'b1;
        end
        step();
        fdone = 1'b0;
    endtask

    task automatic press(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        button = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            lat++;
            if (cam_arm_out) got = 1'b1;
        end
        check("arm_seen", got, 1);
        check("busy_with_arm", busy_out, 1);
        step();
        button = 1'b0;
        m_count = 0;
        m_ovf = 1'b0;
        m_capturing = 1'b1;
        wr_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cam_arm"}, cam_arm_out, 0);
        check({tag, "_wr_en"}, wr_en_out, 0);
        check({tag, "_wr_addr"}, wr_addr_out, 0);
        check({tag, "_wr_data"}, wr_data_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_frame_ready"}, frame_ready_out, 0);
        check({tag, "_pixel_count"}, pixel_count_out, 0);
        check({tag, "_overflow"}, overflow_out, 0);
        check({tag, "_timeout"}, timeout_out, 0);
    endtask

    always @(negedge clk) begin : cmp
        wr_t w;
        if (rst_n) begin
            if (cam_arm_out) begin
                arm_cnt++;
                m_ready = 1'b0;
            end
            check("frame_ready_vs_model", frame_ready_out, m_ready);
            if (wr_en_out) begin
                wr_cnt++;
                if (wr_addr_out < FRAME) bram[wr_addr_out[2:0]] = wr_data_out;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", wr_addr_out, w.addr);
                    check("wr_data", wr_data_out, w.data);
                    check("count_with_write", pixel_count_out, w.addr + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        bit seen;

        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Bouncing button: 2 high, 2 low, for 20 cycles
        for (int i = 0; i < 20; i++) begin
            button = ((i / 2) % 2) == 0;
            step();
        end
        check("no_arm_while_bouncing", arm_cnt, 0);
        press(lat);
        check("arm_latency_in_window", (lat >= 7 && lat <= 9), 1);
        repeat (3) step();
        check("single_arm_pulse", arm_cnt, 1);

        // Full frame
        for (int k = 0; k < FRAME; k++) drive_pixel(16'hA000 + 16'(k), 1'b0);
        end_frame();
        check("full_frame_ready", frame_ready_out, 1);
        check("full_busy", busy_out, 0);
        check("full_count", pixel_count_out, 8);
        check("full_overflow", overflow_out, 0);
        check("full_writes", wr_cnt, 8);
        check("full_bram0", bram[0], 16'hA000);
        check("full_bram7", bram[7], 16'hA007);
        for (int k = 0; k < FRAME; k++) check("full_bram_vs_model", bram[k], m_mem[k]);

        // Pixels and frame_done outside CAPTURE are ignored
        drive_pixel(16'hFFFF, 1'b1);
        step();
        check("done_ignores_pixels", wr_cnt, 8);
        check("done_holds_count", pixel_count_out, 8);

        // Overflow, with a press during CAPTURE that must be ignored
        press(lat);
        button = 1'b1;
        repeat (12) step();
        button = 1'b0;
        repeat (4) step();
        check("press_ignored_in_capture", arm_cnt, 2);
        for (int k = 0; k < FRAME + 2; k++) drive_pixel(16'hB000 + 16'(k), 1'b0);
        end_frame();
        check("ovf_flag", overflow_out, 1);
        check("ovf_model_flag", overflow_out, m_ovf);
        check("ovf_count", pixel_count_out, 8);
        check("ovf_writes", wr_cnt, 8);
        check("ovf_bram7", bram[7], 16'hB007);
        check("ovf_ready", frame_ready_out, 1);

        // Third pixel coincident with frame_done
        press(lat);
        drive_pixel(16'hC000, 1'b0);
        drive_pixel(16'hC001, 1'b0);
        drive_pixel(16'hC002, 1'b1);
        check("sim_wr_en", wr_en_out, 1);
        check("sim_addr", wr_addr_out, 2);
        check("sim_data", wr_data_out, 16'hC002);
        check("sim_count", pixel_count_out, 3);
        check("sim_ready", frame_ready_out, 1);
        check("sim_busy", busy_out, 0);
        step();
        check("sim_wr_en_single", wr_en_out, 0);
        check("sim_writes", wr_cnt, 3);

        press(lat);
`ifdef CAPTURE_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (timeout_out) seen = 1'b1;
        end
        m_capturing = 1'b0;
        check("timeout_seen", seen, 1);
        check("timeout_busy", busy_out, 0);
        check("timeout_ready", frame_ready_out, 0);
        repeat (3) step();
        check("timeout_sticky", timeout_out, 1);
        press(lat);
        check("rearm_clears_timeout", timeout_out, 0);
        check("rearm_busy", busy_out, 1);
`else
        seen = 1'b0;
        repeat (60) step();
        check("no_watchdog_busy", busy_out, 1);
        check("no_watchdog_timeout", timeout_out, 0);
        check("no_watchdog_ready", frame_ready_out, 0);
`endif

        // Async reset in the middle of a capture
        for (int k = 0; k < 3; k++) drive_pixel(16'hD000 + 16'(k), 1'b0);
        step();
        check("pre_reset_count", pixel_count_out, 3);
        #2;
        rst_n = 1'b0;
        #1;
        m_capturing = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        check_all_zero("async_reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        press(lat);
        drive_pixel(16'hE000, 1'b0);
        check("restart_addr", wr_addr_out, 0);
        check("restart_data", wr_data_out, 16'hE000);
        check("restart_count", pixel_count_out, 1);
        end_frame();
        check("restart_ready", frame_ready_out, 1);
        check("restart_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
